// File: rtl/wb_register_file_pkg.sv
// Shared constants for the write-back register file: default widths,
// the hard-wired zero register index and the write-counter width.
package wb_register_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_ZERO   = 0;
    localparam int WR_COUNT_W = 16;

endpackage : wb_register_file_pkg

// File: rtl/wb_bypass_mux.sv
// Per-read-port selection between stored register contents and the in-flight
// write-back value. Forwarding exists only when WB_REGFILE_BYPASS_EN is defined.
module wb_bypass_mux
    import wb_register_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              reset,
    input  logic              wb_regwrite,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_write_data,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] stored_data,
    output logic [DATA_W-1:0] rd_data
);

`ifdef WB_REGFILE_BYPASS_EN
    logic bypass_hit;

    // Forwarding is suppressed in reset so reads stay zero while writes are ignored.
    assign bypass_hit = !reset && wb_regwrite &&
                        (wb_rd != ADDR_W'(REG_ZERO)) && (wb_rd == rd_addr);

    always_comb begin
        // NOTE: rd_data is assigned before any branch so no path leaves it holding a value (no latch).
        rd_data = stored_data;
        if (bypass_hit) begin
            rd_data = wb_write_data;
        end
    end
`else
    logic unused_bypass;

    assign unused_bypass = ^{reset, wb_regwrite, wb_rd, wb_write_data, rd_addr};
    assign rd_data       = stored_data;
`endif

endmodule : wb_bypass_mux

// File: rtl/wb_register_file.sv
// Pipeline register file: one write-back port, two decode read ports and a
// debug read port. Define WB_REGFILE_BYPASS_EN to forward write-back data to rs/rt.
module wb_register_file
    import wb_register_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     wb_write_data,
    input  logic [ADDR_W-1:0]     wb_rd,
    input  logic                  wb_regwrite,
    input  logic [ADDR_W-1:0]     rs_addr,
    input  logic [ADDR_W-1:0]     rt_addr,
    output logic [DATA_W-1:0]     rs_data,
    output logic [DATA_W-1:0]     rt_data,
    input  logic [ADDR_W-1:0]     dbg_addr,
    output logic [DATA_W-1:0]     dbg_data,
    output logic [WR_COUNT_W-1:0] wr_count
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_accept;
    logic [DATA_W-1:0] rs_stored;
    logic [DATA_W-1:0] rt_stored;

    assign wr_accept = wb_regwrite && (wb_rd != ADDR_W'(REG_ZERO));

    // NOTE: the array is built from flops with an async clear, not RAM, because every entry must clear at once on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wr_count <= '0;
        end else if (wr_accept) begin
            // NOTE: non-blocking assignments keep state updates ordered relative to every other clocked reader.
            regs[wb_rd] <= wb_write_data;
            wr_count    <= wr_count + 1'b1;
        end
    end

    // Register 0 is decoded to zero at the read side so its flops can be optimised away.
    assign rs_stored = (rs_addr  == ADDR_W'(REG_ZERO)) ? '0 : regs[rs_addr];
    assign rt_stored = (rt_addr  == ADDR_W'(REG_ZERO)) ? '0 : regs[rt_addr];
    assign dbg_data  = (dbg_addr == ADDR_W'(REG_ZERO)) ? '0 : regs[dbg_addr];

    wb_bypass_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rs_mux (
        .reset         (reset),
        .wb_regwrite   (wb_regwrite),
        .wb_rd         (wb_rd),
        .wb_write_data (wb_write_data),
        .rd_addr       (rs_addr),
        .stored_data   (rs_stored),
        .rd_data       (rs_data)
    );

    wb_bypass_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rt_mux (
        .reset         (reset),
        .wb_regwrite   (wb_regwrite),
        .wb_rd         (wb_rd),
        .wb_write_data (wb_write_data),
        .rd_addr       (rt_addr),
        .stored_data   (rt_stored),
        .rd_data       (rt_data)
    );

endmodule : wb_register_file

// File: tb/tb_wb_register_file.sv
// Scoreboard bench for wb_register_file: stimulus queues expected port values,
// a monitor pops and compares them once per cycle at the falling edge.
module tb_wb_register_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

`ifdef WB_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef enum logic [1:0] {P_RS, P_RT, P_DBG, P_CNT} port_e;
    typedef struct {
        port_e       port;
        logic [31:0] value;
        int          tag;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] wb_write_data;
    logic [ADDR_W-1:0] wb_rd;
    logic              wb_regwrite;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic [15:0]       wr_count;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   tag_n = 0;

    always #5 clk = ~clk;

    wb_register_file #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wb_write_data (wb_write_data),
        .wb_rd         (wb_rd),
        .wb_regwrite   (wb_regwrite),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data),
        .wr_count      (wr_count)
    );

    task automatic check(input string name, input int tag,
                         input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s #%0d: got %h expected %h", name, tag, act, exp);
        end
    endtask

    // Monitor: every queued expectation describes the cycle in which it was pushed.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                case (e.port)
                    P_RS:    check("rs_data",  e.tag, rs_data,  e.value);
                    P_RT:    check("rt_data",  e.tag, rt_data,  e.value);
                    P_DBG:   check("dbg_data", e.tag, dbg_data, e.value);
                    default: check("wr_count", e.tag, {16'h0, wr_count}, e.value);
                endcase
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_port(input port_e p, input logic [31:0] v);
        exp_t e;
        e.port  = p;
        e.value = v;
        e.tag   = tag_n;
        tag_n++;
        sb_q.push_back(e);
    endtask

    task automatic set_read(input int a_rs, input int a_rt, input int a_dbg);
        rs_addr  = ADDR_W'(a_rs);
        rt_addr  = ADDR_W'(a_rt);
        dbg_addr = ADDR_W'(a_dbg);
    endtask

    task automatic wr(input int rd, input logic [31:0] data);
        wb_rd         = ADDR_W'(rd);
        wb_write_data = data;
        wb_regwrite   = 1'b1;
        cyc();
        wb_regwrite   = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        wb_write_data = 32'hFFFF_FFFF;
        wb_rd         = 5'd3;
        wb_regwrite   = 1'b1;
        set_read(3, 3, 3);
        cyc();

        // Reads during reset are zero and the pending write is ignored.
        expect_port(P_RS, 32'h0);
        expect_port(P_RT, 32'h0);
        expect_port(P_DBG, 32'h0);
        expect_port(P_CNT, 32'h0);
        cyc();
        wb_regwrite = 1'b0;
        reset       = 1'b0;

        for (int a = 0; a < 32; a++) begin
            set_read(a, a, a);
            expect_port(P_RS, 32'h0);
            expect_port(P_RT, 32'h0);
            expect_port(P_DBG, 32'h0);
            cyc();
        end
        expect_port(P_CNT, 32'h0);
        cyc();

        wr(5, 32'hDEAD_BEEF);
        set_read(5, 5, 5);
        expect_port(P_RS, 32'hDEAD_BEEF);
        expect_port(P_RT, 32'hDEAD_BEEF);
        expect_port(P_DBG, 32'hDEAD_BEEF);
        expect_port(P_CNT, 32'd1);
        cyc();

        // Write to r0: no forwarding, no storage, no count.
        wb_rd         = 5'd0;
        wb_write_data = 32'h1234_5678;
        wb_regwrite   = 1'b1;
        set_read(0, 5, 0);
        expect_port(P_RS, 32'h0);
        expect_port(P_RT, 32'hDEAD_BEEF);
        cyc();
        wb_regwrite = 1'b0;
        expect_port(P_RS, 32'h0);
        expect_port(P_DBG, 32'h0);
        expect_port(P_CNT, 32'd1);
        cyc();

        // Disabled write-back leaves r5 and the count alone.
        wb_rd         = 5'd5;
        wb_write_data = 32'h0;
        set_read(5, 5, 5);
        cyc();
        expect_port(P_DBG, 32'hDEAD_BEEF);
        expect_port(P_RS, 32'hDEAD_BEEF);
        expect_port(P_CNT, 32'd1);
        cyc();

        wr(7, 32'h1111_1111);
        wb_rd         = 5'd7;
        wb_write_data = 32'hA5A5_A5A5;
        wb_regwrite   = 1'b1;
        set_read(7, 7, 7);
        expect_port(P_RS, BYP ? 32'hA5A5_A5A5 : 32'h1111_1111);
        expect_port(P_RT, BYP ? 32'hA5A5_A5A5 : 32'h1111_1111);
        expect_port(P_DBG, 32'h1111_1111);
        expect_port(P_CNT, 32'd2);
        cyc();
        wb_regwrite = 1'b0;
        expect_port(P_RS, 32'hA5A5_A5A5);
        expect_port(P_RT, 32'hA5A5_A5A5);
        expect_port(P_DBG, 32'hA5A5_A5A5);
        expect_port(P_CNT, 32'd3);
        cyc();

        wr(9, 32'h1);
        set_read(9, 5, 9);
        expect_port(P_DBG, 32'h1);
        expect_port(P_RT, 32'hDEAD_BEEF);
        expect_port(P_CNT, 32'd4);
        cyc();

        // Asynchronous reset between clock edges clears everything at once.
        #1;
        reset = 1'b1;
        expect_port(P_RS, 32'h0);
        expect_port(P_RT, 32'h0);
        expect_port(P_DBG, 32'h0);
        expect_port(P_CNT, 32'h0);
        cyc();

        // A write whose edge coincides with reset assertion is lost.
        reset         = 1'b0;
        wb_rd         = 5'd9;
        wb_write_data = 32'h55;
        wb_regwrite   = 1'b1;
        @(posedge clk);
        reset = 1'b1;
        #1;
        reset       = 1'b0;
        wb_regwrite = 1'b0;
        expect_port(P_DBG, 32'h0);
        expect_port(P_CNT, 32'h0);
        cyc();

        wr(9, 32'h77);
        expect_port(P_DBG, 32'h77);
        expect_port(P_RS, 32'h77);
        expect_port(P_CNT, 32'd1);
        cyc();

        reset = 1'b1;
        cyc();
        reset       = 1'b0;
        wb_regwrite = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            wb_rd         = ADDR_W'((i % 31) + 1);
            wb_write_data = i;
            cyc();
        end
        wb_regwrite = 1'b0;
        set_read(0, 0, 1);
        expect_port(P_CNT, 32'hFFFF);
        expect_port(P_DBG, 32'h0000_FFFE);
        expect_port(P_RS, 32'h0);
        cyc();

        wr(2, 32'hCAFE);
        set_read(2, 0, 2);
        expect_port(P_CNT, 32'h0);
        expect_port(P_DBG, 32'hCAFE);
        cyc();

        cyc();
        cyc();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_wb_register_file
